muldiv_seq: RTL and testbench

Sequential RISC-V M-extension unit covering all eight MDFunc encodings: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Multiplies complete in one cycle.
- Divide/remainder use an iterative radix-2 restoring divider, one quotient bit per cycle.
- Sits in the execute stage beside the ALU; the core stalls on busy and writes back MDOut when done pulses.
- Parametrised in data width and supports a kill for pipeline flushes.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/div_step.sv | 30 +++
 rtl/muldiv_seq.sv | 143 ++++++++++++++
 tb/tb_muldiv_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the sequential RISC-V M-extension unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } mdfunc_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } md_state_t;

  function automatic logic is_signed_div(input mdfunc_t f);
    return (f == MD_DIV) || (f == MD_REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// One iteration of a radix-2 restoring divider: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it does not borrow.
module div_step #(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] rem,
  input  logic [DWIDTH-1:0] quo,
  input  logic [DWIDTH-1:0] divisor,
  output logic [DWIDTH-1:0] rem_next,
  output logic [DWIDTH-1:0] quo_next
);

  logic [DWIDTH:0] shifted;
  logic [DWIDTH:0] diff;

  // rem < divisor always holds, so the shifted value fits in DWIDTH+1 bits and
  // the top bit of the difference is a clean borrow flag.
  always_comb begin
    shifted = {rem, quo[DWIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[DWIDTH]) begin
      rem_next = shifted[DWIDTH-1:0];
      quo_next = {quo[DWIDTH-2:0], 1'b0};
    end else begin
      rem_next = diff[DWIDTH-1:0];
      quo_next = {quo[DWIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential M-extension unit: single-cycle multiplies, iterative restoring
// divide/remainder with sign fix-up, flushable by kill.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              start,
  input  logic              kill,
  input  logic [2:0]        MDFunc,
  input  logic [DWIDTH-1:0] A,
  input  logic [DWIDTH-1:0] B,
  output logic [DWIDTH-1:0] MDOut,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(DWIDTH + 1);

  md_state_t         state, state_next;
  mdfunc_t           func;
  mdfunc_t           req;
  logic [DWIDTH-1:0] opa, opb, rem;
  logic [DWIDTH-1:0] rem_step, quo_step;
  logic [CW-1:0]     count;
  logic              negq, negr;
  logic              sdiv, div_zero, div_ovf, a_neg, b_neg;
  logic [2*DWIDTH-1:0] prod_ss, prod_su, prod_uu, prod_sel;

  assign req      = mdfunc_t'(MDFunc);
  assign busy     = (state != IDLE);
  assign sdiv     = is_signed_div(req);
  assign div_zero = (B == '0);
  assign div_ovf  = sdiv && (A == {1'b1, {(DWIDTH-1){1'b0}}}) && (B == '1);
  assign a_neg    = sdiv & A[DWIDTH-1];
  assign b_neg    = sdiv & B[DWIDTH-1];

  // Operands are extended to the full product width so a plain multiply gives
  // the right low 2*DWIDTH bits for each signedness combination.
  assign prod_ss = {{DWIDTH{opa[DWIDTH-1]}}, opa} * {{DWIDTH{opb[DWIDTH-1]}}, opb};
  assign prod_su = {{DWIDTH{opa[DWIDTH-1]}}, opa} * {{DWIDTH{1'b0}}, opb};
  assign prod_uu = {{DWIDTH{1'b0}}, opa} * {{DWIDTH{1'b0}}, opb};

  always_comb begin
    case (func)
      MD_MULHSU: prod_sel = prod_su;
      MD_MULHU:  prod_sel = prod_uu;
      default:   prod_sel = prod_ss;
    endcase
  end

  div_step #(.DWIDTH(DWIDTH)) u_step (
    .rem      (rem),
    .quo      (opa),
    .divisor  (opb),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (kill) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_next = !MDFunc[2] ? MUL : ((div_zero || div_ovf) ? FIX : DIV);
        MUL:  state_next = IDLE;
        DIV:  if (count == CW'(1)) state_next = FIX;
        FIX:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Divide special cases preload the final quotient/remainder and clear the
  // sign flags, so FIX writes them untouched.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      func  <= MD_MUL;
      opa   <= '0;
      opb   <= '0;
      rem   <= '0;
      count <= '0;
      negq  <= 1'b0;
      negr  <= 1'b0;
      MDOut <= '0;
      done  <= 1'b0;
    end else if (kill) begin
      done  <= 1'b0;
      count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            func <= req;
            negq <= 1'b0;
            negr <= 1'b0;
            if (!MDFunc[2]) begin
              opa <= A;
              opb <= B;
            end else if (div_zero) begin
              opa <= '1;
              rem <= A;
            end else if (div_ovf) begin
              opa <= A;
              rem <= '0;
            end else begin
              opa   <= a_neg ? -A : A;
              opb   <= b_neg ? -B : B;
              rem   <= '0;
              count <= CW'(DWIDTH);
              negq  <= a_neg ^ b_neg;
              negr  <= a_neg;
            end
          end
        end
        MUL: begin
          MDOut <= (func == MD_MUL) ? prod_sel[DWIDTH-1:0] : prod_sel[2*DWIDTH-1:DWIDTH];
          done  <= 1'b1;
        end
        DIV: begin
          rem   <= rem_step;
          opa   <= quo_step;
          count <= count - CW'(1);
        end
        FIX: begin
          MDOut <= func[1] ? (negr ? -rem : rem) : (negq ? -opa : opa);
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table plus a done-driven scoreboard
// that checks both result and completion cycle.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         nReset = 1'b0;
  logic         start = 1'b0;
  logic         kill = 1'b0;
  logic [2:0]   MDFunc = 3'b000;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] MDOut;
  logic         busy;
  logic         done;

  muldiv_seq #(.DWIDTH(W)) dut (
    .clock  (clock),
    .nReset (nReset),
    .start  (start),
    .kill   (kill),
    .MDFunc (MDFunc),
    .A      (A),
    .B      (B),
    .MDOut  (MDOut),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [2:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[20];
  int   tests = 0;
  int   fails = 0;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done must match the oldest pending expectation.
  always @(negedge clock) begin
    exp_t e;
    if (nReset && done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("result", MDOut, e.res);
        checkOutput("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] res, input int lat, input bit track);
    exp_t e;
    MDFunc = f;
    A      = a;
    B      = b;
    start  = 1'b1;
    if (track) begin
      e.res = res;
      e.cyc = cyc + 1 + lat;
      sb.push_back(e);
    end
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL done_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int n;
    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1};
    vecs[4]  = '{3'b000, 32'h12345678, 32'h10,       32'h23456780, 1};
    vecs[5]  = '{3'b011, 32'h80000000, 32'd4,        32'h00000002, 1};
    vecs[6]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[7]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[8]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
    vecs[9]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[10] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[11] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33};
    vecs[12] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33};
    vecs[13] = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[14] = '{3'b111, 32'd5,        32'd0,        32'd5,        1};
    vecs[15] = '{3'b110, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 1};
    vecs[16] = '{3'b101, 32'd0,        32'd0,        32'hFFFFFFFF, 1};
    vecs[17] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[18] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[19] = '{3'b100, 32'h80000000, 32'd1,        32'h80000000, 33};

    #3;
    checkOutput("reset_mdout", MDOut, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_done", {31'b0, done}, 32'h0);
    @(negedge clock);
    nReset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      applyStimulus(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 1'b1);
      checkOutput("busy_after_accept", {31'b0, busy}, 32'h1);
      waitIdle();
      #1 checkOutput("busy_after_done", {31'b0, busy}, 32'h0);
    end

    // A second start while dividing must be dropped.
    @(negedge clock);
    applyStimulus(3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    repeat (9) @(negedge clock);
    MDFunc = 3'b000; A = 32'd3; B = 32'd4; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    checkOutput("busy_ignored_start", {31'b0, busy}, 32'h1);
    waitIdle();

    // Kill mid-divide: no done, MDOut keeps the 14 from above.
    @(negedge clock);
    applyStimulus(3'b100, 32'hFFFFFFF9, 32'd2, 32'h0, 33, 1'b0);
    repeat (14) @(negedge clock);
    kill = 1'b1;
    @(posedge clock);
    #1 kill = 1'b0;
    checkOutput("busy_after_kill", {31'b0, busy}, 32'h0);
    repeat (40) @(negedge clock);
    checkOutput("mdout_after_kill", MDOut, 32'd14);

    // Kill outranks a simultaneous start.
    @(negedge clock);
    kill = 1'b1; start = 1'b1; MDFunc = 3'b000; A = 32'd3; B = 32'd4;
    @(posedge clock);
    #1 begin kill = 1'b0; start = 1'b0; end
    checkOutput("busy_kill_start", {31'b0, busy}, 32'h0);
    repeat (5) @(negedge clock);
    checkOutput("mdout_kill_start", MDOut, 32'd14);

    // Asynchronous reset mid-divide, then a fresh multiply.
    @(negedge clock);
    applyStimulus(3'b101, 32'd100, 32'd7, 32'h0, 33, 1'b0);
    repeat (5) @(negedge clock);
    nReset = 1'b0;
    #1;
    checkOutput("midreset_mdout", MDOut, 32'h0);
    checkOutput("midreset_busy", {31'b0, busy}, 32'h0);
    checkOutput("midreset_done", {31'b0, done}, 32'h0);
    @(negedge clock);
    nReset = 1'b1;
    @(negedge clock);
    applyStimulus(3'b000, 32'd3, 32'd4, 32'd12, 1, 1'b1);
    waitIdle();

    // Back-to-back: MUL issued in the DIV done cycle.
    @(negedge clock);
    applyStimulus(3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33, 1'b1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (done !== 1'b1 && n < 100);
    applyStimulus(3'b000, 32'd5, 32'd6, 32'd30, 1, 1'b1);
    waitIdle();

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
